// File: rtl/wb_regfile_writeback.sv
// wb_regfile_writeback: MEM/WB writeback select, 32x32 register file commit and bypassed read ports
// Optional feature macro: WB_INSTRET_EN adds the 64-bit Instret committed-writeback counter.
// Ports:
//   CLK, Reset                 clock and asynchronous active-high reset
//   WB_Write_Enable            MEM/WB write enable (only a literal 1 commits)
//   WB_Memory_access           1 selects WB_Memory_Data, anything else WB_ALU_Output
//   WB_Memory_Data             load data
//   WB_ALU_Output              ALU result
//   WB_Write_Address           destination register rd
//   Read_Address1/2            ID-stage rs1/rs2
//   Read_Data1/2               combinational read data with same-cycle write bypass
//   WB_Result                  selected writeback value for forwarding
//   WB_Commit                  this cycle's writeback updates a register
//   Instret                    committed-writeback count (WB_INSTRET_EN only)
module wb_regfile_writeback #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              WB_Write_Enable,
    input  logic              WB_Memory_access,
    input  logic [XLEN-1:0]   WB_Memory_Data,
    input  logic [XLEN-1:0]   WB_ALU_Output,
    input  logic [ADDR_W-1:0] WB_Write_Address,
    input  logic [ADDR_W-1:0] Read_Address1,
    input  logic [ADDR_W-1:0] Read_Address2,
    output logic [XLEN-1:0]   Read_Data1,
    output logic [XLEN-1:0]   Read_Data2,
    output logic [XLEN-1:0]   WB_Result,
    output logic              WB_Commit
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]       Instret
`endif
);
    // x0 has no storage; it is hardwired to zero on the read side
    logic [XLEN-1:0] regs [1:NREGS-1];
    // if-statements rather than ternaries so an X/Z control falls to the safe branch
    always_comb begin
        WB_Result = WB_ALU_Output;
        if (WB_Memory_access == 1'b1) WB_Result = WB_Memory_Data;
    end
    always_comb begin
        WB_Commit = 1'b0;
        if (Reset == 1'b0 && WB_Write_Enable == 1'b1 && WB_Write_Address != '0) WB_Commit = 1'b1;
    end
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 1; i < NREGS; i++) regs[i] <= '0;
        end else if (WB_Commit) begin
            regs[WB_Write_Address] <= WB_Result;
        end
    end
    always_comb begin
        Read_Data1 = (Reset || Read_Address1 == '0) ? '0 :
                     (WB_Commit && Read_Address1 == WB_Write_Address) ? WB_Result : regs[Read_Address1];
        Read_Data2 = (Reset || Read_Address2 == '0) ? '0 :
                     (WB_Commit && Read_Address2 == WB_Write_Address) ? WB_Result : regs[Read_Address2];
    end
`ifdef WB_INSTRET_EN
    // counts every enabled writeback, including rd==x0 (NOPs)
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) Instret <= '0;
        else if (WB_Write_Enable == 1'b1) Instret <= Instret + 64'd1;
    end
`endif
endmodule

// File: tb/tb_wb_regfile_writeback.sv
// tb_wb_regfile_writeback: directed self-checking bench for wb_regfile_writeback
module tb_wb_regfile_writeback;
    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        WB_Write_Enable = 1'b0;
    logic        WB_Memory_access = 1'b0;
    logic [31:0] WB_Memory_Data = '0;
    logic [31:0] WB_ALU_Output = '0;
    logic [4:0]  WB_Write_Address = '0;
    logic [4:0]  Read_Address1 = '0;
    logic [4:0]  Read_Address2 = '0;
    logic [31:0] Read_Data1, Read_Data2, WB_Result;
    logic        WB_Commit;
    int          checks = 0;
    int          errors = 0;
    logic        exp_we, exp_mem;
`ifdef WB_INSTRET_EN
    logic [63:0] Instret;
    logic [63:0] exp_cnt = '0;
`endif
    always #5 CLK = ~CLK;
    wb_regfile_writeback dut (
        .CLK(CLK), .Reset(Reset),
        .WB_Write_Enable(WB_Write_Enable), .WB_Memory_access(WB_Memory_access),
        .WB_Memory_Data(WB_Memory_Data), .WB_ALU_Output(WB_ALU_Output),
        .WB_Write_Address(WB_Write_Address),
        .Read_Address1(Read_Address1), .Read_Address2(Read_Address2),
        .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
        .WB_Result(WB_Result), .WB_Commit(WB_Commit)
`ifdef WB_INSTRET_EN
        , .Instret(Instret)
`endif
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask
    initial begin
        // reset held two cycles with a pending write that must be suppressed
        WB_Write_Enable = 1'b1; WB_ALU_Output = 32'h1234; WB_Write_Address = 5'd3;
        Read_Address1 = 5'd3; Read_Address2 = 5'd3;
        cyc(); cyc();
        chk("rst_commit", {63'd0, WB_Commit}, 64'd0);
        chk("rst_rd1", {32'd0, Read_Data1}, 64'd0);
        chk("rst_result", {32'd0, WB_Result}, 64'h1234);
        Reset = 1'b0; WB_Write_Enable = 1'b0;
        for (int a = 1; a < 32; a++) begin
            Read_Address1 = 5'(a); Read_Address2 = 5'(32 - a);
            #1;
            chk("init_rd1", {32'd0, Read_Data1}, 64'd0);
            chk("init_rd2", {32'd0, Read_Data2}, 64'd0);
        end
`ifdef WB_INSTRET_EN
        chk("init_instret", Instret, 64'd0);
`endif
        // ALU writeback to x5 with same-cycle bypass on rs1; rs2 reads an untouched register
        @(negedge CLK);
        WB_Write_Enable = 1'b1; WB_Memory_access = 1'b0; WB_ALU_Output = 32'hDEADBEEF;
        WB_Memory_Data = 32'h0; WB_Write_Address = 5'd5; Read_Address1 = 5'd5; Read_Address2 = 5'd6;
        #1;
        chk("alu_commit", {63'd0, WB_Commit}, 64'd1);
        chk("alu_result", {32'd0, WB_Result}, 64'hDEADBEEF);
        chk("alu_bypass1", {32'd0, Read_Data1}, 64'hDEADBEEF);
        chk("alu_other2", {32'd0, Read_Data2}, 64'd0);
        cyc();
`ifdef WB_INSTRET_EN
        exp_cnt++;
`endif
        WB_Write_Enable = 1'b0;
        #1;
        chk("alu_nocommit", {63'd0, WB_Commit}, 64'd0);
        chk("alu_stored", {32'd0, Read_Data1}, 64'hDEADBEEF);
        // load writeback to x6, both ports bypass
        WB_Write_Enable = 1'b1; WB_Memory_access = 1'b1; WB_Memory_Data = 32'h0BADF00D;
        WB_ALU_Output = 32'h11111111; WB_Write_Address = 5'd6; Read_Address1 = 5'd6; Read_Address2 = 5'd6;
        #1;
        chk("mem_result", {32'd0, WB_Result}, 64'h0BADF00D);
        chk("mem_bypass1", {32'd0, Read_Data1}, 64'h0BADF00D);
        chk("mem_bypass2", {32'd0, Read_Data2}, 64'h0BADF00D);
        cyc();
`ifdef WB_INSTRET_EN
        exp_cnt++;
`endif
        WB_Write_Enable = 1'b0; Read_Address1 = 5'd5;
        #1;
        chk("mem_stored", {32'd0, Read_Data2}, 64'h0BADF00D);
        chk("x5_kept", {32'd0, Read_Data1}, 64'hDEADBEEF);
        // write to x0 is dropped but still counted
        WB_Write_Enable = 1'b1; WB_Memory_access = 1'b1; WB_Memory_Data = 32'h12345678;
        WB_ALU_Output = 32'hFFFFFFFF; WB_Write_Address = 5'd0; Read_Address1 = 5'd0; Read_Address2 = 5'd0;
        #1;
        chk("x0_commit", {63'd0, WB_Commit}, 64'd0);
        chk("x0_result", {32'd0, WB_Result}, 64'h12345678);
        chk("x0_rd1", {32'd0, Read_Data1}, 64'd0);
        chk("x0_rd2", {32'd0, Read_Data2}, 64'd0);
        cyc();
`ifdef WB_INSTRET_EN
        exp_cnt++;
        chk("x0_instret", Instret, exp_cnt);
`endif
        WB_Write_Enable = 1'b0;
        #1;
        chk("x0_after", {32'd0, Read_Data1}, 64'd0);
        // unknown controls as seen right after reset: only a literal 1 may write or select load data
        WB_Write_Enable = 1'bx; WB_Memory_access = 1'bx; WB_ALU_Output = 32'h00000077;
        WB_Memory_Data = 32'h00000099; WB_Write_Address = 5'd7; Read_Address1 = 5'd7;
        exp_we = (WB_Write_Enable === 1'b1);
        exp_mem = (WB_Memory_access === 1'b1);
        #1;
        chk("x_commit", {63'd0, WB_Commit}, {63'd0, exp_we});
        chk("x_result", {32'd0, WB_Result}, exp_mem ? 64'h99 : 64'h77);
        cyc();
`ifdef WB_INSTRET_EN
        if (exp_we) exp_cnt++;
        chk("x_instret", Instret, exp_cnt);
`endif
        WB_Write_Enable = 1'b0; WB_Memory_access = 1'b0;
        #1;
        chk("x_x7", {32'd0, Read_Data1}, exp_we ? (exp_mem ? 64'h99 : 64'h77) : 64'd0);
        // x9 written, then reset asserted mid-cycle over a pending write
        WB_Write_Enable = 1'b1; WB_ALU_Output = 32'hA5A5A5A5; WB_Write_Address = 5'd9;
        Read_Address1 = 5'd9; Read_Address2 = 5'd5;
        cyc();
        WB_ALU_Output = 32'h1;
        #1;
        chk("x9_bypass", {32'd0, Read_Data1}, 64'h1);
        #1;
        Reset = 1'b1;
        #1;
        chk("arst_rd1", {32'd0, Read_Data1}, 64'd0);
        chk("arst_rd2", {32'd0, Read_Data2}, 64'd0);
        chk("arst_commit", {63'd0, WB_Commit}, 64'd0);
        chk("arst_result", {32'd0, WB_Result}, 64'h1);
`ifdef WB_INSTRET_EN
        exp_cnt = '0;
        chk("arst_instret", Instret, exp_cnt);
`endif
        cyc();
        Reset = 1'b0; WB_Write_Enable = 1'b0;
        #1;
        chk("post_x9", {32'd0, Read_Data1}, 64'd0);
        chk("post_x5", {32'd0, Read_Data2}, 64'd0);
`ifdef WB_INSTRET_EN
        // counter wraps from all-ones to zero on one commit
        force dut.Instret = 64'hFFFFFFFFFFFFFFFF;
        #1;
        release dut.Instret;
        WB_Write_Enable = 1'b1; WB_Write_Address = 5'd1; WB_ALU_Output = 32'h5;
        cyc();
        WB_Write_Enable = 1'b0;
        #1;
        chk("wrap_instret", Instret, 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
